// File: rtl/ft6206_pkg.sv
// Shared types and constants for the FT6206 touch poller: I2C byte-master
// command codes, poller FSM encoding and the controller's register map.
package ft6206_pkg;

  typedef enum logic [2:0] {
    I2C_START     = 3'd0,
    I2C_RESTART   = 3'd1,
    I2C_WRITE     = 3'd2,
    I2C_READ_ACK  = 3'd3,
    I2C_READ_NACK = 3'd4,
    I2C_STOP      = 3'd5
  } i2c_cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_ADDR_W     = 4'd2,
    ST_REG        = 4'd3,
    ST_RESTART    = 4'd4,
    ST_ADDR_R     = 4'd5,
    ST_RD0        = 4'd6,
    ST_RD1        = 4'd7,
    ST_RD2        = 4'd8,
    ST_RD3        = 4'd9,
    ST_RD4        = 4'd10,
    ST_STOP       = 4'd11,
    ST_UPDATE     = 4'd12,
    ST_ABORT_STOP = 4'd13
  } poller_state_t;

  localparam logic [7:0] REG_TD_STATUS = 8'h02;
  localparam logic [7:0] REG_P1_XH     = 8'h03;
  localparam logic [6:0] DEFAULT_ADDR  = 7'h38;

  // Only the register bits that carry information are kept.
  typedef struct packed {
    logic [3:0] td_n;
    logic [3:0] xh;
    logic [7:0] xl;
    logic [3:0] yh;
    logic [7:0] yl;
  } raw_regs_t;

  typedef struct packed {
    logic        touched;
    logic [11:0] x;
    logic [11:0] y;
  } touch_sample_t;

  // One or two reported touches count as touched; coordinates hold otherwise.
  function automatic touch_sample_t decode_touch(input raw_regs_t regs,
                                                 input touch_sample_t prev);
    touch_sample_t s;
    s         = prev;
    s.touched = (regs.td_n == 4'd1) || (regs.td_n == 4'd2);
    if (s.touched) begin
      s.x = {regs.xh, regs.xl};
      s.y = {regs.yh, regs.yl};
    end
    return s;
  endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Free-running wrap counter 0..TICKS-1; tick is high for the single cycle
// in which the counter sits at its last value.
module poll_tick_gen #(
  parameter int unsigned TICKS = 120_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output first so no path can infer a latch.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ft6206_touch_poller.sv
// Periodically reads touch point 1 from an FT6206 through a byte-level I2C
// master and publishes the decoded touched/X/Y state.
module ft6206_touch_poller
  import ft6206_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 12_000_000,
  parameter int unsigned POLL_HZ        = 100,
  parameter logic [6:0]  DEV_ADDR       = DEFAULT_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 65_536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  output i2c_cmd_t    i2c_cmd,
  output logic [7:0]  i2c_wdata,
  output logic        i2c_valid,
  input  logic        i2c_ready,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_nack,
  output logic        touched,
  output logic [11:0] touch_x,
  output logic [11:0] touch_y,
  output logic        touch_valid,
  output logic        err
);

  localparam int unsigned POLL_TICKS = CLK_HZ / POLL_HZ;
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] S_IDLE       = ST_IDLE;
  localparam logic [3:0] S_START      = ST_START;
  localparam logic [3:0] S_ADDR_W     = ST_ADDR_W;
  localparam logic [3:0] S_REG        = ST_REG;
  localparam logic [3:0] S_RESTART    = ST_RESTART;
  localparam logic [3:0] S_ADDR_R     = ST_ADDR_R;
  localparam logic [3:0] S_RD0        = ST_RD0;
  localparam logic [3:0] S_RD1        = ST_RD1;
  localparam logic [3:0] S_RD2        = ST_RD2;
  localparam logic [3:0] S_RD3        = ST_RD3;
  localparam logic [3:0] S_RD4        = ST_RD4;
  localparam logic [3:0] S_STOP       = ST_STOP;
  localparam logic [3:0] S_UPDATE     = ST_UPDATE;
  localparam logic [3:0] S_ABORT_STOP = ST_ABORT_STOP;

  logic             poll_tick;
  logic [3:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic             wait_q, wait_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  raw_regs_t        regs_q, regs_d;
  touch_sample_t    sample_q, sample_d;
  logic             tv_q, tv_d;
  logic             err_q, err_d;

  i2c_cmd_t         cmd_cur;
  logic [7:0]       wdata_cur;
  logic             is_write;
  logic [3:0]       next_state;
  logic             cmd_accept, cmd_done, cmd_timeout;

  poll_tick_gen #(
    .TICKS(POLL_TICKS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(poll_tick)
  );

  // Command and write byte are pure functions of the state, so they stay
  // stable for as long as the state waits on the handshake.
  always_comb begin
    cmd_cur   = I2C_START;
    wdata_cur = 8'h00;
    is_write  = 1'b0;
    case (state_q)
      S_START:   cmd_cur = I2C_START;
      S_ADDR_W:  begin cmd_cur = I2C_WRITE; wdata_cur = {DEV_ADDR, 1'b0}; is_write = 1'b1; end
      S_REG:     begin cmd_cur = I2C_WRITE; wdata_cur = REG_TD_STATUS;     is_write = 1'b1; end
      S_RESTART: cmd_cur = I2C_RESTART;
      S_ADDR_R:  begin cmd_cur = I2C_WRITE; wdata_cur = {DEV_ADDR, 1'b1}; is_write = 1'b1; end
      S_RD0, S_RD1, S_RD2, S_RD3: cmd_cur = I2C_READ_ACK;
      S_RD4:     cmd_cur = I2C_READ_NACK;
      S_STOP, S_ABORT_STOP: cmd_cur = I2C_STOP;
      default:   ;
    endcase
  end

  always_comb begin
    next_state = S_IDLE;
    case (state_q)
      S_START:   next_state = S_ADDR_W;
      S_ADDR_W:  next_state = S_REG;
      S_REG:     next_state = S_RESTART;
      S_RESTART: next_state = S_ADDR_R;
      S_ADDR_R:  next_state = S_RD0;
      S_RD0:     next_state = S_RD1;
      S_RD1:     next_state = S_RD2;
      S_RD2:     next_state = S_RD3;
      S_RD3:     next_state = S_RD4;
      S_RD4:     next_state = S_STOP;
      S_STOP:    next_state = S_UPDATE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    wait_d   = wait_q;
    tmo_d    = tmo_q;
    regs_d   = regs_q;
    sample_d = sample_q;
    tv_d     = 1'b0;
    err_d    = 1'b0;

    // valid_q and wait_q are never both set, so at most one of these fires.
    cmd_accept  = valid_q & i2c_ready;
    cmd_done    = wait_q & i2c_done;
    cmd_timeout = wait_q & ~i2c_done & (tmo_q == TMO_LAST);

    if (state_q == S_IDLE) begin
      if (poll_tick && ena) begin
        state_d = S_START;
        valid_d = 1'b1;
      end
    end else if (state_q == S_UPDATE) begin
      sample_d = decode_touch(regs_q, sample_q);
      tv_d     = 1'b1;
      state_d  = S_IDLE;
    end else if (cmd_accept) begin
      valid_d = 1'b0;
      wait_d  = 1'b1;
      tmo_d   = '0;
    end else if (cmd_done) begin
      wait_d = 1'b0;
      if (is_write && i2c_nack) begin
        state_d = S_ABORT_STOP;
        valid_d = 1'b1;
        err_d   = 1'b1;
      end else begin
        case (state_q)
          S_RD0:   regs_d.td_n = i2c_rdata[3:0];
          S_RD1:   regs_d.xh   = i2c_rdata[3:0];
          S_RD2:   regs_d.xl   = i2c_rdata;
          S_RD3:   regs_d.yh   = i2c_rdata[3:0];
          S_RD4:   regs_d.yl   = i2c_rdata;
          default: ;
        endcase
        state_d = next_state;
        valid_d = (next_state != S_UPDATE) && (next_state != S_IDLE);
      end
    end else if (cmd_timeout) begin
      wait_d = 1'b0;
      // A stuck STOP during abort has nowhere left to go but idle.
      if (state_q == S_ABORT_STOP) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_ABORT_STOP;
        valid_d = 1'b1;
        err_d   = 1'b1;
      end
    end else if (wait_q) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      wait_q   <= 1'b0;
      tmo_q    <= '0;
      sample_q <= '0;
      tv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      sample_q <= sample_d;
      tv_q     <= tv_d;
      err_q    <= err_d;
    end
  end

  // NOTE: capture registers are not reset; every byte is rewritten before UPDATE reads it.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign i2c_cmd     = cmd_cur;
  assign i2c_wdata   = wdata_cur;
  assign i2c_valid   = valid_q;
  assign touched     = sample_q.touched;
  assign touch_x     = sample_q.x;
  assign touch_y     = sample_q.y;
  assign touch_valid = tv_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ft6206_touch_poller.sv
// Directed bench: a behavioural I2C byte master serves canned register bytes
// and the poller's command stream, decode and error handling are checked.
module tb_ft6206_touch_poller;

  localparam int T       = 256;  // 25_600 / 100
  localparam int TMO     = 64;
  localparam int DONE_LAT = 4;

  localparam logic [10:0] C_START   = {3'd0, 8'h00};
  localparam logic [10:0] C_RESTART = {3'd1, 8'h00};
  localparam logic [10:0] C_W70     = {3'd2, 8'h70};
  localparam logic [10:0] C_W02     = {3'd2, 8'h02};
  localparam logic [10:0] C_W71     = {3'd2, 8'h71};
  localparam logic [10:0] C_RACK    = {3'd3, 8'h00};
  localparam logic [10:0] C_RNACK   = {3'd4, 8'h00};
  localparam logic [10:0] C_STOP    = {3'd5, 8'h00};

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [2:0]  i2c_cmd;
  logic [7:0]  i2c_wdata;
  logic        i2c_valid, i2c_ready, i2c_done, i2c_nack;
  logic [7:0]  i2c_rdata;
  logic        touched, touch_valid, err;
  logic [11:0] touch_x, touch_y;

  ft6206_touch_poller #(
    .CLK_HZ(25_600), .POLL_HZ(100), .DEV_ADDR(7'h38), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .i2c_cmd(i2c_cmd), .i2c_wdata(i2c_wdata), .i2c_valid(i2c_valid),
    .i2c_ready(i2c_ready), .i2c_done(i2c_done), .i2c_rdata(i2c_rdata),
    .i2c_nack(i2c_nack), .touched(touched), .touch_x(touch_x),
    .touch_y(touch_y), .touch_valid(touch_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int tv_count = 0, err_count = 0, err_cyc = 0, valid_cycles = 0;
  int first_valid_cyc = -1, rack_acc_cyc = 0;
  int stable_err = 0, proto_err = 0;
  int stall_cycles = 0, nack_write_idx = -1;
  bit drop_read_done = 1'b0;
  logic [7:0]  rd_bytes [5];
  logic [10:0] log_q [$];
  logic [10:0] exp_q [$];

  // Master-side state
  int m_st = 0, m_cnt = 0, rd_idx = 0, wr_idx = 0;
  logic [2:0] c0;
  logic [7:0] w0, rdata_now;
  bit nack_now, drop_now;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (touch_valid) tv_count++;
    if (err) begin err_count++; err_cyc = cyc; end
    if (i2c_valid) valid_cycles++;
  end

  initial begin : master
    i2c_ready = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (rst) begin
        i2c_ready = 1'b0;
        m_st = 0;
      end else begin
        case (m_st)
          0: if (i2c_valid) begin
               c0 = i2c_cmd; w0 = i2c_wdata;
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               if (stall_cycles > 0) begin m_cnt = stall_cycles; m_st = 1; end
               else begin i2c_ready = 1'b1; m_st = 2; end
             end
          1: begin
               if (!i2c_valid || i2c_cmd !== c0 || i2c_wdata !== w0) stable_err++;
               m_cnt--;
               if (m_cnt == 0) begin i2c_ready = 1'b1; m_st = 2; end
             end
          2: begin
               i2c_ready = 1'b0;
               if (i2c_valid) proto_err++;
               if (c0 == 3'd0) begin log_q.delete(); rd_idx = 0; wr_idx = 0; end
               log_q.push_back({c0, (c0 == 3'd2) ? w0 : 8'h00});
               nack_now = 1'b0;
               rdata_now = 8'h00;
               if (c0 == 3'd2) begin nack_now = (wr_idx == nack_write_idx); wr_idx++; end
               if ((c0 == 3'd3 || c0 == 3'd4) && rd_idx < 5) begin
                 rdata_now = rd_bytes[rd_idx]; rd_idx++;
               end
               if (c0 == 3'd3) rack_acc_cyc = cyc;
               drop_now = drop_read_done && (c0 == 3'd3);
               m_cnt = DONE_LAT;
               m_st = drop_now ? 0 : 3;
             end
          default: begin
               m_cnt--;
               if (m_cnt == 0) begin
                 i2c_done = 1'b1; i2c_nack = nack_now; i2c_rdata = rdata_now; m_st = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic set_bytes(input logic [7:0] b0, b1, b2, b3, b4);
    rd_bytes[0] = b0; rd_bytes[1] = b1; rd_bytes[2] = b2; rd_bytes[3] = b3; rd_bytes[4] = b4;
  endtask

  task automatic load_normal_seq();
    exp_q = {C_START, C_W70, C_W02, C_RESTART, C_W71, C_RACK, C_RACK, C_RACK, C_RACK, C_RNACK, C_STOP};
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  // Waits for the poll in flight (or the next one) to end with touch_valid or err.
  task automatic do_poll(input string tag, input int budget, input int exp_tv, input int exp_err);
    int tv0, e0;
    bit got;
    tv0 = tv_count; e0 = err_count; got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (tv_count != tv0 || err_count != e0) begin got = 1'b1; break; end
    end
    check({tag, "_ended"}, got, 1'b1);
    repeat (24) @(posedge clk);
    #1;
    check({tag, "_tv_pulses"}, tv_count - tv0, exp_tv);
    check({tag, "_err_pulses"}, err_count - e0, exp_err);
  endtask

  task automatic check_outputs(input string tag, input logic t, input logic [11:0] x, y);
    check({tag, "_touched"}, touched, t);
    check({tag, "_x"}, touch_x, x);
    check({tag, "_y"}, touch_y, y);
  endtask

  initial begin : main
    int rel_cyc;
    int v0;
    bit got;
    rst = 1'b1; ena = 1'b1;
    set_bytes(8'h01, 8'h81, 8'h2C, 8'h02, 8'hF0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 12'h000, 12'h000);
    check("reset_tv", touch_valid, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_valid", i2c_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;

    // First poll: timing, command order, n=1 decode
    load_normal_seq();
    do_poll("pollA", 2 * T, 1, 0);
    check("first_start_cycle", first_valid_cyc - rel_cyc, T);
    check_seq("pollA");
    check_outputs("pollA", 1'b1, 12'h12C, 12'h2F0);

    set_bytes(8'h00, 8'h11, 8'h22, 8'h03, 8'h44);
    do_poll("pollB", 2 * T, 1, 0);
    check_outputs("pollB_n0", 1'b0, 12'h12C, 12'h2F0);

    set_bytes(8'h0F, 8'h85, 8'h55, 8'h06, 8'h66);
    do_poll("pollC", 2 * T, 1, 0);
    check_outputs("pollC_n15", 1'b0, 12'h12C, 12'h2F0);

    set_bytes(8'h02, 8'h8A, 8'hBC, 8'h0D, 8'hEF);
    do_poll("pollD", 2 * T, 1, 0);
    check_outputs("pollD_n2", 1'b1, 12'hABC, 12'hDEF);

    // NACK on the address write aborts with STOP only
    nack_write_idx = 0;
    do_poll("nack", 2 * T, 0, 1);
    exp_q = {C_START, C_W70, C_STOP};
    check_seq("nack");
    check_outputs("nack", 1'b1, 12'hABC, 12'hDEF);
    nack_write_idx = -1;

    set_bytes(8'h01, 8'h05, 8'h67, 8'h08, 8'h9A);
    load_normal_seq();
    do_poll("after_nack", 2 * T, 1, 0);
    check_seq("after_nack");
    check_outputs("after_nack", 1'b1, 12'h567, 12'h89A);

    // Missing done after READ_ACK
    drop_read_done = 1'b1;
    do_poll("timeout", 2 * T, 0, 1);
    check("timeout_delay", err_cyc - rack_acc_cyc, TMO);
    exp_q = {C_START, C_W70, C_W02, C_RESTART, C_W71, C_RACK, C_STOP};
    check_seq("timeout");
    check_outputs("timeout", 1'b1, 12'h567, 12'h89A);
    drop_read_done = 1'b0;

    // Polling disabled
    ena = 1'b0;
    v0 = valid_cycles;
    repeat (3 * T) @(posedge clk);
    #1;
    check("ena_low_no_valid", valid_cycles - v0, 0);
    ena = 1'b1;

    // ena dropped mid-poll
    set_bytes(8'h01, 8'h00, 8'h00, 8'h0F, 8'hFF);
    got = 1'b0;
    for (int i = 0; i < 2 * T; i++) begin
      @(posedge clk); #1;
      if (i2c_valid) begin got = 1'b1; break; end
    end
    check("ena_drop_poll_started", got, 1'b1);
    repeat (5) @(posedge clk);
    ena = 1'b0;
    load_normal_seq();
    do_poll("ena_drop", 2 * T, 1, 0);
    check_seq("ena_drop");
    check_outputs("ena_drop", 1'b1, 12'h000, 12'hFFF);
    ena = 1'b1;

    // Slow ready: command must stay stable while stalled
    stall_cycles = 10;
    set_bytes(8'h02, 8'h03, 8'h45, 8'h06, 8'h78);
    do_poll("stall", 3 * T, 1, 0);
    check_seq("stall");
    check("stall_stable", stable_err, 0);
    check("valid_drop_after_accept", proto_err, 0);
    check_outputs("stall", 1'b1, 12'h345, 12'h678);

    // Reset while RD2 is being offered
    stall_cycles = 20;
    got = 1'b0;
    for (int i = 0; i < 3 * T; i++) begin
      @(posedge clk); #1;
      if (log_q.size() == 7 && i2c_valid) begin got = 1'b1; break; end
    end
    check("rd2_reached", got, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs("mid_rst", 1'b0, 12'h000, 12'h000);
    check("mid_rst_valid", i2c_valid, 1'b0);
    check("mid_rst_tv", touch_valid, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_cmd", {i2c_cmd, i2c_wdata}, 11'h000);
    @(negedge clk);
    rst = 1'b0;
    stall_cycles = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
